// File: rtl/i2c_slave_regs.sv
// I2C target exposing a 4-byte register file, with a combinational local read port.
// Optional macro I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
`timescale 1ns/1ps
module i2c_slave_regs #(
  parameter logic [6:0]  SLV_ADDR = 7'h63,
  parameter logic [31:0] MEM_INIT = 32'h0000_0000
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       i2c_scl,
  inout  logic       i2c_sda,
  input  logic [1:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_DATA  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_DATA  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_c, sda_c, scl_p, sda_p;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx;
  logic [1:0] ptr;
  logic       sda_low;
  logic [7:0] mem [4];

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl};
      sda_sync <= {sda_sync[0], i2c_sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end
  assign scl_c = (scl_hist[0] & scl_hist[1]) | (scl_hist[1] & scl_hist[2]) | (scl_hist[0] & scl_hist[2]);
  assign sda_c = (sda_hist[0] & sda_hist[1]) | (sda_hist[1] & sda_hist[2]) | (sda_hist[0] & sda_hist[2]);
`else
  assign scl_c = scl_sync[1];
  assign sda_c = sda_sync[1];
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_c;
      sda_p <= sda_c;
    end
  end

  assign scl_rise  = scl_c & ~scl_p;
  assign scl_fall  = ~scl_c & scl_p;
  assign start_det = scl_c & scl_p & sda_p & ~sda_c;
  assign stop_det  = scl_c & scl_p & ~sda_p & sda_c;

  assign i2c_sda   = sda_low ? 1'b0 : 1'bz;
  assign loc_rdata = mem[loc_addr];

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      sda_low  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      mem[0]   <= MEM_INIT[7:0];
      mem[1]   <= MEM_INIT[15:8];
      mem[2]   <= MEM_INIT[23:16];
      mem[3]   <= MEM_INIT[31:24];
    end else begin
      rx_valid <= 1'b0;
      if (stop_det) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        ptr     <= '0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= {shreg[5:0], sda_c};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              // shreg already holds address bits [7:1]; the current sample is R/W
              if (shreg == SLV_ADDR) begin
                state <= ADDR_ACK;
                tx[0] <= sda_c;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
              busy    <= 1'b1;
            end else if (tx[0]) begin
              // first read bit goes out on the same falling edge that ends the ACK
              state   <= RD_DATA;
              sda_low <= ~mem[ptr][7];
              tx      <= {mem[ptr][6:0], 1'b0};
              bit_cnt <= 4'd1;
            end else begin
              state   <= WR_DATA;
              sda_low <= 1'b0;
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg   <= {shreg[5:0], sda_c};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              mem[ptr] <= {shreg, sda_c};
              rx_data  <= {shreg, sda_c};
              rx_valid <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else begin
              sda_low <= 1'b0;
              ptr     <= ptr + 2'd1;
              state   <= WR_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= RD_ACK;
            end else if (bit_cnt == 4'd0) begin
              sda_low <= ~mem[ptr][7];
              tx      <= {mem[ptr][6:0], 1'b0};
            end else begin
              sda_low <= ~tx[7];
              tx      <= {tx[6:0], 1'b0};
            end
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_c) begin
              ptr     <= ptr + 2'd1;
              bit_cnt <= '0;
              state   <= RD_DATA;
            end else begin
              busy  <= 1'b0;
              state <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master with table-driven byte checks.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 80;
  localparam int H = 120;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [1:0] loc_addr = '0;
  logic [7:0] loc_rdata, rx_data;
  logic       rx_valid, busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_regs #(.SLV_ADDR(7'h63), .MEM_INIT(32'hA55A_C33C)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .i2c_scl(scl), .i2c_sda(sda_bus),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  int unsigned rxv_cnt = 0;
  int unsigned slv_low_cnt = 0;
  int unsigned busy_cnt = 0;

  always @(posedge PCLK) begin
    if (rx_valid) rxv_cnt++;
    if (sda_bus === 1'b0 && !m_sda_low) slv_low_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct { logic [1:0] a; logic [7:0] exp; } loc_vec_t;
  typedef struct { logic [7:0] exp; logic nack; } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0; #Q; scl = 1'b1; #Q; m_sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; #Q; scl = 1'b1; #Q; m_sda_low = 1'b0; #H;
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = !b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; #Q; scl = 1'b1; #(H/2); b = sda_bus; #(H/2); scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic loc_read(input logic [1:0] a, output logic [7:0] d);
    loc_addr = a; #1; d = loc_rdata;
  endtask

  initial begin
    loc_vec_t    init_tab[4];
    loc_vec_t    wrap_tab[4];
    rd_vec_t     rd_tab[4];
    logic [7:0]  wr5[5];
    logic [7:0]  d;
    logic        ack, b;
    int unsigned rx0, low0, busy0;

    init_tab[0] = '{2'd0, 8'h3C}; init_tab[1] = '{2'd1, 8'hC3};
    init_tab[2] = '{2'd2, 8'h5A}; init_tab[3] = '{2'd3, 8'hA5};
    wrap_tab[0] = '{2'd0, 8'h55}; wrap_tab[1] = '{2'd1, 8'h22};
    wrap_tab[2] = '{2'd2, 8'h33}; wrap_tab[3] = '{2'd3, 8'h44};
    rd_tab[0] = '{8'hAB, 1'b0}; rd_tab[1] = '{8'hCD, 1'b0};
    rd_tab[2] = '{8'h12, 1'b0}; rd_tab[3] = '{8'h34, 1'b1};
    wr5[0] = 8'h11; wr5[1] = 8'h22; wr5[2] = 8'h33; wr5[3] = 8'h44; wr5[4] = 8'h55;

    // reset state
    repeat (4) @(posedge PCLK);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_sda", 32'(sda_bus), 32'd1);
    @(negedge PCLK); PRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      loc_read(init_tab[i].a, d);
      check($sformatf("init_mem%0d", i), 32'(d), 32'(init_tab[i].exp));
    end
    #(4*Q);

    // wrong address is ignored completely
    rx0 = rxv_cnt; low0 = slv_low_cnt; busy0 = busy_cnt;
    i2c_start;
    write_byte({7'h62, 1'b0}, ack);
    check("nomatch_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h99, ack);
    check("nomatch_data_ack", 32'(ack), 32'd1);
    i2c_stop;
    check("nomatch_sda_low", slv_low_cnt - low0, 32'd0);
    check("nomatch_rx_valid", rxv_cnt - rx0, 32'd0);
    check("nomatch_busy", busy_cnt - busy0, 32'd0);
    loc_read(2'd0, d);
    check("nomatch_mem0", 32'(d), 32'h3C);

    // two-byte write
    rx0 = rxv_cnt;
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    check("wr2_addr_ack", 32'(ack), 32'd0);
    check("wr2_busy", 32'(busy), 32'd1);
    write_byte(8'hAB, ack);
    check("wr2_ack0", 32'(ack), 32'd0);
    write_byte(8'hCD, ack);
    check("wr2_ack1", 32'(ack), 32'd0);
    check("wr2_rx_data", 32'(rx_data), 32'hCD);
    i2c_stop;
    check("wr2_rx_valid_count", rxv_cnt - rx0, 32'd2);
    check("wr2_busy_after_stop", 32'(busy), 32'd0);
    loc_read(2'd0, d); check("wr2_mem0", 32'(d), 32'hAB);
    loc_read(2'd1, d); check("wr2_mem1", 32'(d), 32'hCD);

    // five-byte write wraps the pointer
    rx0 = rxv_cnt;
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    check("wr5_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      write_byte(wr5[i], ack);
      check($sformatf("wr5_ack%0d", i), 32'(ack), 32'd0);
    end
    i2c_stop;
    check("wr5_rx_valid_count", rxv_cnt - rx0, 32'd5);
    for (int i = 0; i < 4; i++) begin
      loc_read(wrap_tab[i].a, d);
      check($sformatf("wr5_mem%0d", i), 32'(d), 32'(wrap_tab[i].exp));
    end

    // STOP after 5 bits discards the partial byte
    rx0 = rxv_cnt;
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    check("part_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 5; i++) put_bit(1'b1);
    i2c_stop;
    check("part_rx_valid", rxv_cnt - rx0, 32'd0);
    check("part_state_idle", 32'(dut.state), 32'd0);
    check("part_busy", 32'(busy), 32'd0);
    loc_read(2'd0, d); check("part_mem0", 32'(d), 32'h55);

`ifdef I2C_SLV_GLITCH_FILTER_EN
    // a 1-PCLK SCL pulse during the low phase must not shift a bit
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    check("glitch_addr_ack", 32'(ack), 32'd0);
    d = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = !d[i]; #(Q/2);
      if (i == 4) begin
        @(negedge PCLK); scl = 1'b1; @(negedge PCLK); scl = 1'b0;
      end
      #(Q/2); scl = 1'b1; #H; scl = 1'b0; #Q;
    end
    get_bit(ack);
    check("glitch_ack", 32'(ack), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'h5A);
    i2c_stop;
`endif

    // load AB,CD,12,34 then read back with NACK on the last byte
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    for (int i = 0; i < 4; i++) write_byte(rd_tab[i].exp, ack);
    i2c_stop;
    i2c_start;
    write_byte({7'h63, 1'b1}, ack);
    check("rd_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_byte(d, rd_tab[i].nack);
      check($sformatf("rd_byte%0d", i), 32'(d), 32'(rd_tab[i].exp));
    end
    get_bit(b);
    check("rd_released_after_nack", 32'(b), 32'd1);
    check("rd_state_ignore", 32'(dut.state), 32'd7);
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop;
    check("rd_state_idle", 32'(dut.state), 32'd0);

    // reset during bit 4 of a read byte (AB: bit 4 is 0)
    i2c_start;
    write_byte({7'h63, 1'b1}, ack);
    check("rst_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) get_bit(b);
    m_sda_low = 1'b0; #Q; scl = 1'b1; #(H/2);
    check("rst_bit4_driven_low", 32'(sda_bus), 32'd0);
    @(negedge PCLK); PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("rst_sda_released", 32'(sda_bus), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    #(H/2); scl = 1'b0; #Q;
    loc_read(2'd0, d); check("rst_mem0_init", 32'(d), 32'h3C);
    i2c_start;
    write_byte({7'h63, 1'b0}, ack);
    check("rst_next_addr_ack", 32'(ack), 32'd0);
    check("rst_next_busy", 32'(busy), 32'd1);
    i2c_stop;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
